// File: rtl/mem_access_stage_pkg.sv
// Shared pipeline definitions for the memory stage and its MEM/WB consumers.
package mem_access_stage_pkg;

  localparam int unsigned DbitsDefault   = 32;
  localparam int unsigned RegbitsDefault = 4;
  localparam int unsigned TimeoutDefault = 15;

  // Memory-stage access sequencer states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StAbort = 2'd2
  } mem_state_e;

  // MEM/WB bundle as seen by the write-back stage (default widths).
  typedef struct packed {
    logic                      valid;
    logic                      reg_write;
    logic [RegbitsDefault-1:0] wr_reg;
    logic [DbitsDefault-1:0]   result;
    logic                      misalign_err;
    logic                      bus_err;
  } mem_wb_t;

  // Word accesses only: the low two address bits must be clear.
  function automatic logic is_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads a retiring instruction or inserts a bubble.
module mem_wb_reg #(
  parameter int unsigned DBITS   = 32,
  parameter int unsigned REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               retire,
  input  logic               reg_write_nxt,
  input  logic [REGBITS-1:0] wr_reg_nxt,
  input  logic [DBITS-1:0]   result_nxt,
  input  logic               misalign_nxt,
  input  logic               bus_err_nxt,
  output logic               valid_w,
  output logic               regWrite_w,
  output logic [REGBITS-1:0] wrReg_w,
  output logic [DBITS-1:0]   result_w,
  output logic               misalign_err,
  output logic               bus_err
);

  // Control bits clear on a bubble; destination and result hold their last value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_w      <= 1'b0;
      regWrite_w   <= 1'b0;
      wrReg_w      <= '0;
      result_w     <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      valid_w      <= retire;
      regWrite_w   <= retire & reg_write_nxt;
      misalign_err <= retire & misalign_nxt;
      bus_err      <= retire & bus_err_nxt;
      if (retire) begin
        wrReg_w  <= wr_reg_nxt;
        result_w <= result_nxt;
      end
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory stage: req/ack data-memory access, stall, timeout abort, MEM/WB select.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned DBITS   = DbitsDefault,
  parameter int unsigned REGBITS = RegbitsDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               valid_m,
  input  logic               memtoReg_m,
  input  logic               memWrite_m,
  input  logic               jal_m,
  input  logic               regWrite_m,
  input  logic [REGBITS-1:0] wrReg_m,
  input  logic [DBITS-1:0]   incrementedPC_m,
  input  logic [DBITS-1:0]   aluOut_m,
  input  logic [DBITS-1:0]   sr2Out_m,
  output logic               stall_m,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DBITS-1:0]   dmem_addr,
  output logic [DBITS-1:0]   dmem_wdata,
  input  logic [DBITS-1:0]   dmem_rdata,
  input  logic               dmem_ack,
  output logic               valid_w,
  output logic               regWrite_w,
  output logic [REGBITS-1:0] wrReg_w,
  output logic [DBITS-1:0]   result_w,
  output logic               misalign_err,
  output logic               bus_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  mem_state_e      state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

  logic             memop, aligned;
  logic             misalign, abort_err, retire, reg_write_nxt;
  logic [DBITS-1:0] result_nxt;

  assign memop      = valid_m & (memtoReg_m | memWrite_m);
  assign aligned    = is_aligned(aluOut_m[1:0]);
  assign dmem_we    = memWrite_m;
  assign dmem_addr  = aluOut_m;
  assign dmem_wdata = sr2Out_m;

  // Sequencer state and wait-cycle counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next state: count wait cycles while unacknowledged, abort once the budget is spent.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (dmem_req && !dmem_ack) begin
          state_d    = StWait;
          wait_cnt_d = CntW'(1);
        end
      end
      StWait: begin
        if (dmem_ack) begin
          state_d    = StIdle;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CntW'(TIMEOUT)) begin
          state_d    = StAbort;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      StAbort: begin
        state_d = StIdle;
      end
      default: begin
        state_d    = StIdle;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Bus request, stall, error classification and retire decision.
  always_comb begin
    // The request is gated by reset so a held instruction cannot reach the bus during reset.
    dmem_req      = reset_n & memop & aligned & (state_q != StAbort);
    stall_m       = dmem_req & ~dmem_ack;
    misalign      = memop & ~aligned;
    abort_err     = memop & (state_q == StAbort);
    retire        = valid_m & ~stall_m;
    reg_write_nxt = regWrite_m & ~(misalign | abort_err);
  end

  // Write-back value select; jal wins over a load.
  always_comb begin
    if (jal_m) begin
      result_nxt = incrementedPC_m;
    end else if (memtoReg_m) begin
      result_nxt = dmem_rdata;
    end else begin
      result_nxt = aluOut_m;
    end
  end

  mem_wb_reg #(
    .DBITS   (DBITS),
    .REGBITS (REGBITS)
  ) u_mem_wb_reg (
    .clk           (clk),
    .reset_n       (reset_n),
    .retire        (retire),
    .reg_write_nxt (reg_write_nxt),
    .wr_reg_nxt    (wrReg_m),
    .result_nxt    (result_nxt),
    .misalign_nxt  (misalign),
    .bus_err_nxt   (abort_err),
    .valid_w       (valid_w),
    .regWrite_w    (regWrite_w),
    .wrReg_w       (wrReg_w),
    .result_w      (result_w),
    .misalign_err  (misalign_err),
    .bus_err       (bus_err)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table plus multi-cycle wait, timeout and reset sequences.
module tb_mem_access_stage;

  localparam int unsigned DBITS   = 32;
  localparam int unsigned REGBITS = 4;
  localparam int unsigned TIMEOUT = 15;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               valid_m, memtoReg_m, memWrite_m, jal_m, regWrite_m;
  logic [REGBITS-1:0] wrReg_m;
  logic [DBITS-1:0]   incrementedPC_m, aluOut_m, sr2Out_m;
  logic               stall_m, dmem_req, dmem_we;
  logic [DBITS-1:0]   dmem_addr, dmem_wdata, dmem_rdata;
  logic               dmem_ack;
  logic               valid_w, regWrite_w;
  logic [REGBITS-1:0] wrReg_w;
  logic [DBITS-1:0]   result_w;
  logic               misalign_err, bus_err;

  always #5 clk = ~clk;

  mem_access_stage #(
    .DBITS   (DBITS),
    .REGBITS (REGBITS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .valid_m         (valid_m),
    .memtoReg_m      (memtoReg_m),
    .memWrite_m      (memWrite_m),
    .jal_m           (jal_m),
    .regWrite_m      (regWrite_m),
    .wrReg_m         (wrReg_m),
    .incrementedPC_m (incrementedPC_m),
    .aluOut_m        (aluOut_m),
    .sr2Out_m        (sr2Out_m),
    .stall_m         (stall_m),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_rdata      (dmem_rdata),
    .dmem_ack        (dmem_ack),
    .valid_w         (valid_w),
    .regWrite_w      (regWrite_w),
    .wrReg_w         (wrReg_w),
    .result_w        (result_w),
    .misalign_err    (misalign_err),
    .bus_err         (bus_err)
  );

  // Expected MEM/WB contents of one retiring instruction.
  typedef struct {
    logic        rw;
    logic        mis;
    logic        bus;
    logic        chk_res;
    logic [3:0]  wr;
    logic [31:0] res;
  } exp_t;

  typedef struct {
    logic        valid, mtr, mw, jal, rw, ack;
    logic [3:0]  wr;
    logic [31:0] pc, alu, sr2, rdata;
    logic        e_req, e_stall, e_ret;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_miss = 0;
  vec_t tbl[12];
  vec_t v;
  exp_t none;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] ef, input logic [3:0] wr, input logic [31:0] res);
    exp_t e;
    e.rw      = ef[3];
    e.mis     = ef[2];
    e.bus     = ef[1];
    e.chk_res = ef[0];
    e.wr      = wr;
    e.res     = res;
    return e;
  endfunction

  // ctl = {valid, memtoReg, memWrite, jal, regWrite}; eo = {req, stall, retire};
  // ef = {regWrite_w, misalign_err, bus_err, check result}.
  function automatic vec_t mkv(input logic [4:0] ctl, input logic [3:0] wr,
                               input logic [31:0] pc, input logic [31:0] alu,
                               input logic [31:0] sr2, input logic ack,
                               input logic [31:0] rdata, input logic [2:0] eo,
                               input logic [3:0] ef, input logic [31:0] res);
    vec_t r;
    r.valid   = ctl[4];
    r.mtr     = ctl[3];
    r.mw      = ctl[2];
    r.jal     = ctl[1];
    r.rw      = ctl[0];
    r.wr      = wr;
    r.pc      = pc;
    r.alu     = alu;
    r.sr2     = sr2;
    r.ack     = ack;
    r.rdata   = rdata;
    r.e_req   = eo[2];
    r.e_stall = eo[1];
    r.e_ret   = eo[0];
    r.e       = mk(ef, wr, res);
    return r;
  endfunction

  task automatic drive(input vec_t d);
    valid_m         = d.valid;
    memtoReg_m      = d.mtr;
    memWrite_m      = d.mw;
    jal_m           = d.jal;
    regWrite_m      = d.rw;
    wrReg_m         = d.wr;
    incrementedPC_m = d.pc;
    aluOut_m        = d.alu;
    sr2Out_m        = d.sr2;
    dmem_ack        = d.ack;
    dmem_rdata      = d.rdata;
  endtask

  // Compare the MEM/WB register against the scoreboard (one-cycle retire latency).
  task automatic check_retire();
    exp_t e;
    if (valid_w) begin
      if (sb.size() == 0) begin
        chk("unexpected retire valid_w", 32'(valid_w), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("regWrite_w", 32'(regWrite_w), 32'(e.rw));
        chk("wrReg_w", 32'(wrReg_w), 32'(e.wr));
        chk("misalign_err", 32'(misalign_err), 32'(e.mis));
        chk("bus_err", 32'(bus_err), 32'(e.bus));
        if (e.chk_res) chk("result_w", result_w, e.res);
      end
    end else begin
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("missing retire valid_w", 32'(valid_w), 32'd1);
      end
      chk("bubble regWrite_w", 32'(regWrite_w), 32'd0);
      chk("bubble misalign_err", 32'(misalign_err), 32'd0);
      chk("bubble bus_err", 32'(bus_err), 32'd0);
    end
  endtask

  // One cycle: check at the falling edge, then advance past the rising edge.
  task automatic step(input logic e_req, input logic e_stall, input logic e_ret, input exp_t e);
    @(negedge clk);
    check_retire();
    chk("dmem_req", 32'(dmem_req), 32'(e_req));
    chk("stall_m", 32'(stall_m), 32'(e_stall));
    if (e_ret) sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t d);
    drive(d);
    #2;
    chk("dmem_addr", dmem_addr, d.alu);
    chk("dmem_wdata", dmem_wdata, d.sr2);
    chk("dmem_we", 32'(dmem_we), 32'(d.mw));
    step(d.e_req, d.e_stall, d.e_ret, d.e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  initial begin
    none = mk(4'b0000, 4'd0, 32'd0);
    //            ctl        wr     pc            alu           sr2           ack   rdata          eo      ef       res
    tbl[0]  = mkv(5'b10001, 4'd3,  32'h0000_0008, 32'h0000_0010, 32'h0,        1'b0, 32'hAAAA_AAAA, 3'b001, 4'b1001, 32'h0000_0010);
    tbl[1]  = mkv(5'b10101, 4'd5,  32'h0000_000C, 32'h0000_0204, 32'h0000_1234, 1'b1, 32'h0,        3'b101, 4'b1001, 32'h0000_0204);
    tbl[2]  = mkv(5'b10100, 4'd6,  32'h0000_0010, 32'h0000_0208, 32'h0000_5678, 1'b1, 32'h0,        3'b101, 4'b0001, 32'h0000_0208);
    tbl[3]  = mkv(5'b11001, 4'd7,  32'h0000_0014, 32'h0000_0100, 32'h0,        1'b1, 32'hCAFE_F00D, 3'b101, 4'b1001, 32'hCAFE_F00D);
    tbl[4]  = mkv(5'b10011, 4'd15, 32'h0000_0044, 32'h0000_0999, 32'h0,        1'b0, 32'h0,        3'b001, 4'b1001, 32'h0000_0044);
    tbl[5]  = mkv(5'b11011, 4'd1,  32'h0000_0048, 32'h0000_0080, 32'h0,        1'b1, 32'h5555_5555, 3'b101, 4'b1001, 32'h0000_0048);
    tbl[6]  = mkv(5'b11001, 4'd2,  32'h0000_004C, 32'h0000_0102, 32'h0,        1'b1, 32'h0000_0001, 3'b001, 4'b0100, 32'h0);
    tbl[7]  = mkv(5'b10101, 4'd4,  32'h0000_0050, 32'h0000_0203, 32'h0000_0077, 1'b0, 32'h0,        3'b001, 4'b0100, 32'h0);
    tbl[8]  = mkv(5'b01001, 4'd8,  32'h0000_0054, 32'h0000_0100, 32'h0,        1'b1, 32'h1234_5678, 3'b000, 4'b0000, 32'h0);
    tbl[9]  = mkv(5'b10000, 4'd9,  32'h0000_0058, 32'hFFFF_FFFC, 32'h0,        1'b0, 32'h0,        3'b001, 4'b0001, 32'hFFFF_FFFC);
    tbl[10] = mkv(5'b10001, 4'd10, 32'h0000_005C, 32'h0000_0001, 32'h0,        1'b0, 32'h0,        3'b001, 4'b1001, 32'h0000_0001);
    tbl[11] = mkv(5'b11000, 4'd11, 32'h0000_0060, 32'h0000_0300, 32'h0,        1'b1, 32'h0BAD_0000, 3'b101, 4'b0001, 32'h0BAD_0000);

    // Reset with an aligned load presented: no request may escape.
    reset_n = 1'b0;
    drive(tbl[3]);
    dmem_ack = 1'b0;
    #3;
    chk("reset dmem_req", 32'(dmem_req), 32'd0);
    chk("reset stall_m", 32'(stall_m), 32'd0);
    chk("reset valid_w", 32'(valid_w), 32'd0);
    chk("reset regWrite_w", 32'(regWrite_w), 32'd0);
    chk("reset wrReg_w", 32'(wrReg_w), 32'd0);
    chk("reset result_w", result_w, 32'd0);
    chk("reset misalign_err", 32'(misalign_err), 32'd0);
    chk("reset bus_err", 32'(bus_err), 32'd0);
    drive(tbl[8]);
    valid_m = 1'b0;
    dmem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) apply(tbl[i]);

    // Load acknowledged after three wait cycles.
    v = mkv(5'b11001, 4'd12, 32'h64, 32'h100, 32'h0, 1'b0, 32'h0, 3'b110, 4'b1001, 32'hDEAD_BEEF);
    drive(v);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, none);
    dmem_rdata = 32'hDEAD_BEEF;
    dmem_ack   = 1'b1;
    step(1'b1, 1'b0, 1'b1, v.e);
    apply(tbl[0]);

    // Load never acknowledged: TIMEOUT+1 stall cycles, then one abort cycle.
    v = mkv(5'b11001, 4'd13, 32'h68, 32'h104, 32'h0, 1'b0, 32'h0, 3'b110, 4'b0010, 32'h0);
    drive(v);
    for (int i = 0; i < int'(TIMEOUT) + 1; i++) step(1'b1, 1'b1, 1'b0, none);
    dmem_ack = 1'b1;  // late ack during abort is ignored
    step(1'b0, 1'b0, 1'b1, v.e);
    apply(tbl[4]);
    apply(tbl[3]);

    // Reset asserted while waiting on an access.
    v = mkv(5'b11001, 4'd14, 32'h6C, 32'h108, 32'h0, 1'b0, 32'h0, 3'b110, 4'b1001, 32'h0);
    drive(v);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, none);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midwait dmem_req", 32'(dmem_req), 32'd0);
    chk("midwait stall_m", 32'(stall_m), 32'd0);
    chk("midwait valid_w", 32'(valid_w), 32'd0);
    chk("midwait regWrite_w", 32'(regWrite_w), 32'd0);
    chk("midwait wrReg_w", 32'(wrReg_w), 32'd0);
    chk("midwait result_w", result_w, 32'd0);
    chk("midwait misalign_err", 32'(misalign_err), 32'd0);
    chk("midwait bus_err", 32'(bus_err), 32'd0);
    valid_m = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    apply(tbl[0]);
    apply(tbl[1]);
    apply(tbl[8]);

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the 5-stage pipeline, sitting directly downstream of the EX/MEM pipeline register. It performs data-memory loads and stores over a wait-state-tolerant request/acknowledge bus and stalls upstream stages while an access is outstanding. It selects the write-back result and registers it into the MEM/WB pipeline register consumed by the write-back stage. A bounded wait counter aborts hung accesses with an error pulse.

## Interface
- DBITS, 32, data/address width
- REGBITS, 4, register-index width
- TIMEOUT, 15, maximum wait cycles before abort (≥1)
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- valid_m  in  1  EX/MEM holds a live instruction
- memtoReg_m, memWrite_m, jal_m, regWrite_m  in  1 each  control bits from EX/MEM
- wrReg_m  in  REGBITS  destination register
- incrementedPC_m, aluOut_m, sr2Out_m  in  DBITS  PC+4, ALU result/address, store data
- stall_m  out  1  hold EX/MEM and all upstream registers this cycle
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr, dmem_wdata  out  DBITS  byte address (= aluOut_m), store data (= sr2Out_m)
- dmem_rdata  in  DBITS  load data, valid with dmem_ack
- dmem_ack  in  1  access complete
- valid_w, regWrite_w  out  1  MEM/WB valid, register-write enable
- wrReg_w  out  REGBITS  MEM/WB destination
- result_w  out  DBITS  MEM/WB write-back value
- misalign_err, bus_err  out  1  one-cycle error pulses

## Operation
- memop = valid_m & (memtoReg_m | memWrite_m); aligned = aluOut_m[1:0] == 0.
- dmem_req = memop & aligned & (state != ABORT); forced 0 while reset_n low. dmem_addr/dmem_wdata/dmem_we are combinational pass-throughs.
- stall_m = dmem_req & ~dmem_ack.
- FSM states IDLE, WAIT, ABORT:
  - IDLE: dmem_req & ack → retire, stay IDLE. dmem_req & ~ack → WAIT, wait_cnt = 1.
  - WAIT: ack → retire, IDLE, wait_cnt = 0. ~ack & wait_cnt == TIMEOUT → ABORT. Otherwise wait_cnt += 1 (width clog2(TIMEOUT+1), never wraps).
  - ABORT: dmem_req = 0, stall_m = 0; instruction retires with regWrite_w = 0, bus_err pulse; → IDLE.
- Misaligned memop: no request, no stall; retires next cycle with regWrite_w = 0, misalign_err pulse.
- Non-memop valid instruction: retires with no stall.
- Retire (registered into MEM/WB on that edge): valid_w = 1, wrReg_w = wrReg_m, regWrite_w = regWrite_m & ~error, result_w = jal_m ? incrementedPC_m : memtoReg_m ? dmem_rdata : aluOut_m (jal priority).
- Stall cycle or valid_m = 0: MEM/WB loads a bubble (valid_w = 0, regWrite_w = 0); wrReg_w/result_w hold.
- Upstream holds EX/MEM inputs constant while stall_m is high; inputs changing mid-WAIT are a protocol violation (not checked).

## Timing
- Reset (async assert, sync-released use): state IDLE, wait_cnt 0, valid_w 0, regWrite_w 0, wrReg_w 0, result_w 0, misalign_err 0, bus_err 0.
- Zero-wait memory (ack in request cycle): 0 stall cycles; result_w valid 1 cycle after valid_m.
- N-cycle ack (N ≤ TIMEOUT): stall_m high N cycles; retire on the ack cycle's edge.
- No ack: stall_m high TIMEOUT+1 cycles (IDLE + TIMEOUT WAIT cycles), 1 ABORT cycle, bus_err asserted the cycle after ABORT.
- Error pulses are registered, coincident with the valid_w of the faulting instruction.
- Reset mid-WAIT: FSM to IDLE immediately; dmem_req drops same cycle; in-flight access discarded.
- Ack arriving in ABORT or IDLE without a request: ignored.

## Structure
- Shared pipeline package: mem-stage state encoding (IDLE/WAIT/ABORT), DBITS/REGBITS defaults, the MEM/WB bundle field list shared with the write-back stage.
- One natural sub-module: mem_wb_reg (MEM/WB register with bubble insert and async active-low reset); FSM, counter and result mux stay in the top.

## Test plan
- ALU op, valid_m=1, regWrite_m=1, aluOut_m=0x0000_0010, wrReg_m=3 → next cycle valid_w=1, result_w=0x10, wrReg_w=3, stall_m never high.
- Load, aluOut_m=0x100, ack after 3 cycles with dmem_rdata=0xDEAD_BEEF → stall_m high 3 cycles, bubbles meanwhile, then result_w=0xDEAD_BEEF, regWrite_w=1.
- Store, aluOut_m=0x204, sr2Out_m=0x1234, zero-wait ack → dmem_we=1, dmem_addr=0x204, dmem_wdata=0x1234, no stall, regWrite_w follows regWrite_m.
- Load with aluOut_m=0x102 → dmem_req never asserted, misalign_err=1 for one cycle with valid_w=1, regWrite_w=0.
- Load, ack never arrives, TIMEOUT=15 → stall_m high 16 cycles, bus_err pulse, regWrite_w=0, FSM back to IDLE, following ALU op retires normally.
- jal with memtoReg_m=0, incrementedPC_m=0x44 → result_w=0x44; reset_n pulsed low mid-WAIT → dmem_req drops immediately, all outputs at reset values.
